// File: rtl/connect4_pkg.sv
// Shared Connect-4 types: cell encoding, default board size, move-engine FSM states.
package connect4_pkg;
  typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10} cell_t;

  localparam int BOARD_ROWS = 6;
  localparam int BOARD_COLS = 7;

  typedef enum logic {IDLE, SCAN} move_gen_state_t;
endpackage

// File: rtl/lfsr_rng.sv
// Free-running 8-bit Fibonacci LFSR (taps 7,5,4,3); seed loading exists only
// when MOVE_GEN_SEED_EN is defined.
module lfsr_rng #(
  parameter int LFSR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr
`ifdef MOVE_GEN_SEED_EN
  ,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed
`endif
);
  logic fb;
  assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_W'(1);
`ifdef MOVE_GEN_SEED_EN
    // an all-zero state would lock the LFSR, so a zero seed maps to 1
    else if (seed_load) lfsr <= (seed == '0) ? LFSR_W'(1) : seed;
`endif
    else lfsr <= {lfsr[LFSR_W-2:0], fb};
  end
endmodule

// File: rtl/random_move_engine.sv
// Connect-4 AI move source: random start column, wrap-around scan of the top row,
// one column per cycle. Seed ports exist only when MOVE_GEN_SEED_EN is defined.
module random_move_engine
  import connect4_pkg::*;
#(
  parameter  int ROWS   = BOARD_ROWS,
  parameter  int COLS   = BOARD_COLS,
  parameter  int LFSR_W = 8,
  localparam int COL_W  = $clog2(COLS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  cell_t [0:ROWS-1][0:COLS-1]   board,
  output logic                         busy,
  output logic                         done,
  output logic                         valid,
  output logic [COL_W-1:0]             col
`ifdef MOVE_GEN_SEED_EN
  ,
  input  logic                         seed_load,
  input  logic [LFSR_W-1:0]            seed
`endif
);
  localparam logic [COL_W-1:0] LAST = COL_W'(COLS - 1);

  move_gen_state_t   state;
  logic [LFSR_W-1:0] lfsr;
  logic [COL_W-1:0]  offset, cur_col, step;
  logic              unused_rows;

  // only the top row decides playability
  assign unused_rows = ^board;

  lfsr_rng #(.LFSR_W(LFSR_W)) u_rng (
    .clk       (clk),
    .rst       (rst),
    .lfsr      (lfsr)
`ifdef MOVE_GEN_SEED_EN
    ,
    .seed_load (seed_load),
    .seed      (seed)
`endif
  );

  assign offset = COL_W'(lfsr % LFSR_W'(COLS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
      col     <= '0;
      cur_col <= '0;
      step    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (req) begin
          cur_col <= offset;
          step    <= '0;
          state   <= SCAN;
          busy    <= 1'b1;
        end
        SCAN: begin
          if (board[0][cur_col] == EMPTY) begin
            col   <= cur_col;
            valid <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (step == LAST) begin
            col   <= '0;
            valid <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cur_col <= (cur_col == LAST) ? '0 : cur_col + 1'b1;
            step    <= step + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_random_move_engine.sv
// Scoreboard bench: a model predicts each result from the LFSR rule and a modular
// scan of the top row; a negedge monitor compares whenever a result is due.
module tb_random_move_engine;
  import connect4_pkg::*;

  localparam int COLS = 7;
  localparam int ROWS = 6;

  logic clk = 1'b0;
  logic rst, req, req4;
  cell_t [0:ROWS-1][0:COLS-1] board;
  cell_t [0:2][0:3]           board4;
  logic       busy, done, valid;
  logic [2:0] col;
  logic       busy4, done4, valid4;
  logic [1:0] col4;
`ifdef MOVE_GEN_SEED_EN
  logic       seed_load;
  logic [7:0] seed;
`endif

  random_move_engine #(.ROWS(ROWS), .COLS(COLS), .LFSR_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .board(board),
    .busy(busy), .done(done), .valid(valid), .col(col)
`ifdef MOVE_GEN_SEED_EN
    , .seed_load(seed_load), .seed(seed)
`endif
  );

  random_move_engine #(.ROWS(3), .COLS(4), .LFSR_W(8)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .board(board4),
    .busy(busy4), .done(done4), .valid(valid4), .col(col4)
`ifdef MOVE_GEN_SEED_EN
    , .seed_load(1'b0), .seed(8'h00)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int due; int col; bit valid;} exp_t;
  exp_t q[$];

  int   checks = 0, errors = 0;
  logic [7:0] mlfsr = 8'h01;
  int   idle_from = 0, acc_cyc = -1;
  int   hcol = 0;
  bit   hvalid = 1'b0, armed = 1'b0;
  bit   pend4 = 1'b0;
  int   dl4 = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // first empty column walking right from lfsr mod COLS, wrapping
  function automatic void predict(input logic [7:0] l, output int c, output bit v,
                                  output int lat);
    int off;
    off = int'(l) % COLS;
    v = 1'b0; c = 0; lat = COLS + 1;
    for (int k = 0; k < COLS; k++)
      if (!v && board[0][(off + k) % COLS] == EMPTY) begin
        v = 1'b1; c = (off + k) % COLS; lat = k + 2;
      end
  endfunction

  always @(negedge clk) begin
    int c, lat;
    bit v;
    if (armed) begin
      check("busy", int'(busy), int'(cyc > acc_cyc && cyc < idle_from));
      if (q.size() > 0 && q[0].due == cyc) begin
        check("done", int'(done), 1);
        check("col", int'(col), q[0].col);
        check("valid", int'(valid), int'(q[0].valid));
        hcol = q[0].col; hvalid = q[0].valid;
        void'(q.pop_front());
      end else begin
        check("done_quiet", int'(done), 0);
        check("col_hold", int'(col), hcol);
        check("valid_hold", int'(valid), int'(hvalid));
      end
      if (pend4) begin
        if (done4) begin
          check("small_col", int'(col4), 2);
          check("small_valid", int'(valid4), 1);
          check("small_busy_end", int'(busy4), 0);
          pend4 = 1'b0;
        end else if (cyc >= dl4) begin
          check("small_timeout", 0, 1);
          pend4 = 1'b0;
        end else check("small_busy", int'(busy4), 1);
      end else check("small_done_quiet", int'(done4), 0);
    end
    // model consumes this cycle's inputs, as the DUT will on the next edge
    if (rst) begin
      mlfsr = 8'h01; q.delete(); hcol = 0; hvalid = 1'b0;
      idle_from = cyc + 1; acc_cyc = cyc; armed = 1'b1; pend4 = 1'b0;
    end else begin
      if (req && cyc >= idle_from) begin
        predict(mlfsr, c, v, lat);
        q.push_back('{due: cyc + lat, col: c, valid: v});
        acc_cyc = cyc; idle_from = cyc + lat;
      end
      if (req4 && !pend4) begin pend4 = 1'b1; dl4 = cyc + 5; end
`ifdef MOVE_GEN_SEED_EN
      if (seed_load) mlfsr = (seed == 8'h00) ? 8'h01 : seed;
      else
`endif
      mlfsr = {mlfsr[6:0], ^(mlfsr & 8'hB8)};
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue();
    req = 1'b1; step(); req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && !(cyc >= idle_from && q.size() == 0); i++) step();
  endtask

  task automatic fill_top(input int free_mask, input bit rnd_codes);
    for (int c = 0; c < COLS; c++) begin
      if (free_mask[c]) board[0][c] = EMPTY;
      else if (rnd_codes) board[0][c] = cell_t'(2'($urandom_range(1, 3)));
      else board[0][c] = (c % 2 == 0) ? P1 : P2;
    end
  endtask

`ifdef MOVE_GEN_SEED_EN
  task automatic load_seed(input logic [7:0] s);
    seed = s; seed_load = 1'b1; step(); seed_load = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; req = 1'b0; req4 = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) board[r][c] = cell_t'(2'($urandom_range(0, 3)));
`ifdef MOVE_GEN_SEED_EN
    seed_load = 1'b0; seed = 8'h00;
`endif
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) board4[r][c] = (c == 2 && r == 0) ? EMPTY : P2;
    repeat (4) step();
    rst = 1'b0;
    step();

    fill_top(7'h7f, 1'b0);                  // empty board
    issue(); wait_idle();
    fill_top(7'h00, 1'b0);                  // full top row
    issue(); wait_idle();

    // reset abandons a scan: req in cycle 0, rst in cycle 3
    fill_top(7'h00, 1'b1);
    issue(); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    fill_top(7'h7f, 1'b0);
    issue(); wait_idle();

`ifdef MOVE_GEN_SEED_EN
    load_seed(8'h03); issue(); wait_idle();
    load_seed(8'h00); issue(); wait_idle();
    fill_top(7'h1f, 1'b0);                  // columns 5,6 full -> wrap to 0
    load_seed(8'h05); issue(); wait_idle();
`endif

    for (int it = 0; it < 60; it++) begin
      int mode;
      mode = $urandom_range(0, 3);
      fill_top(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 127)), 1'b1);
`ifdef MOVE_GEN_SEED_EN
      if ($urandom_range(0, 3) == 0) load_seed(8'($urandom_range(0, 255)));
`endif
      issue();
      if (mode == 1) begin
        repeat ($urandom_range(0, 3)) step();
        issue();                            // during SCAN: must be ignored
      end else if (mode == 2) begin
        for (int i = 0; i < 20 && cyc < idle_from; i++) step();
        fill_top(int'($urandom_range(0, 127)), 1'b1);
        issue();                            // issued in the done cycle
      end
      wait_idle();
      if (mode == 3) repeat ($urandom_range(1, 4)) step();
    end

    // 4-column instance, only column 2 free
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(0, 5)) step();
      req4 = 1'b1; step(); req4 = 1'b0;
      for (int i = 0; i < 10 && pend4; i++) step();
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
